// File: rtl/bcd_pulse_gen.sv
// BCD-count pulse burst generator: emits N single-cycle pulses for a two-digit
// BCD request, spaced by GAP_CYCLES idle cycles, clocked on the falling edge.
module bcd_pulse_gen #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk_n,
  input  logic       clr_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] bcd_in,
  input  logic       abort,
  output logic       pulse_out,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned GAP_W = 4;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_remaining;
  logic [7:0]       w_rem_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_ready;

  logic             w_accept;
  logic             w_bad;
  logic [7:0]       w_dec;
  logic             w_pulse_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_ready_nxt;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_bad    = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);

  // BCD decrement with borrow from tens; only used while remaining is non-zero
  assign w_dec = (r_remaining[3:0] != 4'd0) ?
                 {r_remaining[7:4], r_remaining[3:0] - 4'd1} :
                 {r_remaining[7:4] - 4'd1, 4'd9};

  always_ff @(negedge clk_n or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_bad) begin
          w_rem_nxt   = bcd_in;
          w_state_nxt = (bcd_in == 8'h00) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        w_rem_nxt = w_dec;
        if (w_dec == 8'h00) begin
          w_state_nxt = S_DONE;
        end else if (GAP_CYCLES == 0) begin
          w_state_nxt = S_PULSE;
        end else begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(0)) w_state_nxt = S_PULSE;
        else                        w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything once a burst is in flight
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = 8'h00;
    end
  end

  always_comb begin
    w_pulse_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_ready_nxt = 1'b0;
    w_pulse_nxt = (w_state_nxt == S_PULSE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_err_nxt   = w_accept && w_bad;
    w_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(negedge clk_n or negedge clr_n) begin
    if (!clr_n) begin
      r_remaining <= 8'h00;
      r_gap_cnt   <= GAP_W'(0);
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_remaining <= w_rem_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_pulse     <= w_pulse_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  assign in_ready  = r_ready;
  assign pulse_out = r_pulse;
  assign remaining = r_remaining;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
